// File: rtl/icap_reboot_pkg.sv
// Shared types and ICAPE2 command words for the warm-reboot scheduler.
package icap_reboot_pkg;

  typedef enum logic [1:0] {IDLE, ARM, SEND, HALT} state_t;

  localparam int unsigned ADDR_W = 24;

  localparam logic [31:0] ICAP_DUMMY     = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC      = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOP       = 32'h2000_0000;
  localparam logic [31:0] ICAP_WR_WBSTAR = 32'h3002_0001;
  localparam logic [31:0] ICAP_WR_CMD    = 32'h3000_8001;
  localparam logic [31:0] ICAP_CMD_IPROG = 32'h0000_000F;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] data;
  } icap_word_t;

  // Dummy, sync, NOP, WBSTAR cmd, WBSTAR value, CMD cmd, IPROG, then trailing NOPs.
  function automatic int unsigned seq_len(input int unsigned trail_nops);
    return 32'd7 + trail_nops;
  endfunction

endpackage

// File: rtl/icap_seq_rom.sv
// Combinational IPROG word table; inserts the latched WBSTAR address at word 4.
module icap_seq_rom
  import icap_reboot_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [ADDR_W-1:0] addr,
  output icap_word_t        word
);

  always_comb begin
    word.ce   = 1'b1;
    word.we   = 1'b1;
    word.data = ICAP_NOP;
    case (idx)
      IDX_W'(0): begin
        word.ce   = 1'b0;
        word.we   = 1'b0;
        word.data = ICAP_DUMMY;
      end
      IDX_W'(1): word.data = ICAP_SYNC;
      IDX_W'(2): word.data = ICAP_NOP;
      IDX_W'(3): word.data = ICAP_WR_WBSTAR;
      IDX_W'(4): word.data = {8'h00, addr};
      IDX_W'(5): word.data = ICAP_WR_CMD;
      IDX_W'(6): word.data = ICAP_CMD_IPROG;
      default:   word.data = ICAP_NOP;
    endcase
  end

endmodule

// File: rtl/icap_reboot_sched.sv
// Fixed-priority warm-reboot scheduler: arbitrate, arm (abortable), emit IPROG, lock out.
module icap_reboot_sched
  import icap_reboot_pkg::*;
#(
  parameter int unsigned                NUM_REQ    = 2,
  parameter int unsigned                NUM_SLOTS  = 4,
  parameter int unsigned                SLOT_W     = 2,
  parameter logic [NUM_SLOTS*24-1:0]    SLOT_BASE  = {24'h000300, 24'h000200, 24'h000100, 24'h000000},
  parameter int unsigned                ARM_CYCLES = 16,
  parameter int unsigned                TRAIL_NOPS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*SLOT_W-1:0] req_slot,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      abort,
  output logic                      busy,
  output logic                      armed,
  output logic                      err_slot,
  output logic                      icap_ce,
  output logic                      icap_we,
  output logic [31:0]               icap_data
);

  localparam int unsigned SEQ_LEN = seq_len(TRAIL_NOPS);
  localparam int unsigned IDX_W   = $clog2(SEQ_LEN + 1);
  localparam int unsigned CNT_W   = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

  state_t              state;
  logic                pend;
  logic [SLOT_W-1:0]   slot_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    arm_cnt;
  logic [IDX_W-1:0]    idx;

  logic                req_any;
  logic [NUM_REQ-1:0]  req_onehot;
  logic [SLOT_W-1:0]   req_slot_sel;
  logic                slot_bad;
  logic [ADDR_W-1:0]   slot_addr;
  icap_word_t          word;

  // Lowest set index wins; scanning downward lets the lowest overwrite.
  always_comb begin
    req_onehot   = '0;
    req_slot_sel = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        req_onehot    = '0;
        req_onehot[i] = 1'b1;
        req_slot_sel  = req_slot[SLOT_W*i +: SLOT_W];
      end
    end
  end

  assign req_any  = |req;
  assign slot_bad = 32'(slot_q) >= NUM_SLOTS;

  always_comb begin
    slot_addr = '0;
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      if (32'(slot_q) == 32'(s)) slot_addr = SLOT_BASE[24*s +: 24];
    end
  end

  icap_seq_rom #(.IDX_W(IDX_W)) u_rom (
    .idx  (idx),
    .addr (addr_q),
    .word (word)
  );

  // The grant cycle is spent in IDLE with pend set, so slot checking lands on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= 1'b0;
      slot_q    <= '0;
      addr_q    <= '0;
      arm_cnt   <= '0;
      idx       <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      armed     <= 1'b0;
      err_slot  <= 1'b0;
      icap_ce   <= 1'b0;
      icap_we   <= 1'b0;
      icap_data <= ICAP_DUMMY;
    end else begin
      grant     <= '0;
      err_slot  <= 1'b0;
      icap_ce   <= 1'b0;
      icap_we   <= 1'b0;
      icap_data <= ICAP_DUMMY;
      case (state)
        IDLE: begin
          if (pend) begin
            pend <= 1'b0;
            if (slot_bad) begin
              err_slot <= 1'b1;
            end else begin
              addr_q <= slot_addr;
              busy   <= 1'b1;
              if (ARM_CYCLES == 0) begin
                state <= SEND;
                idx   <= '0;
              end else begin
                state   <= ARM;
                armed   <= 1'b1;
                arm_cnt <= CNT_W'(ARM_CYCLES - 1);
              end
            end
          end else if (req_any) begin
            grant  <= req_onehot;
            slot_q <= req_slot_sel;
            pend   <= 1'b1;
          end
        end
        ARM: begin
          if (abort) begin
            state <= IDLE;
            armed <= 1'b0;
            busy  <= 1'b0;
          end else if (arm_cnt == '0) begin
            state <= SEND;
            armed <= 1'b0;
            idx   <= '0;
          end else begin
            arm_cnt <= arm_cnt - CNT_W'(1);
          end
        end
        SEND: begin
          icap_ce   <= word.ce;
          icap_we   <= word.we;
          icap_data <= word.data;
          if (idx == IDX_W'(SEQ_LEN - 1)) state <= HALT;
          else                            idx   <= idx + IDX_W'(1);
        end
        HALT: begin
          busy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_reboot_sched.sv
// Randomised self-checking bench for icap_reboot_sched, one armed and one zero-arm instance.
module tb_icap_reboot_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [3:0]  req_slot = '0;
  logic        abort = 1'b0;

  logic [1:0]  g0, g1;
  logic        b0, b1, a0, a1, e0, e1, ce0, ce1, we0, we1;
  logic [31:0] d0, d1;

  bit          sel;
  logic [1:0]  o_grant;
  logic        o_busy, o_armed, o_err, o_ce, o_we;
  logic [31:0] o_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  icap_reboot_sched #(
    .NUM_REQ(2), .NUM_SLOTS(3), .SLOT_W(2),
    .SLOT_BASE(72'h000200_000100_000000),
    .ARM_CYCLES(16), .TRAIL_NOPS(8)
  ) dut0 (
    .clk(clk), .rst(rst), .req(req), .req_slot(req_slot), .grant(g0), .abort(abort),
    .busy(b0), .armed(a0), .err_slot(e0), .icap_ce(ce0), .icap_we(we0), .icap_data(d0)
  );

  icap_reboot_sched #(
    .NUM_REQ(2), .NUM_SLOTS(4), .SLOT_W(2),
    .SLOT_BASE(96'h000300_000200_000100_000000),
    .ARM_CYCLES(0), .TRAIL_NOPS(8)
  ) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_slot(req_slot), .grant(g1), .abort(abort),
    .busy(b1), .armed(a1), .err_slot(e1), .icap_ce(ce1), .icap_we(we1), .icap_data(d1)
  );

  always_comb begin
    if (sel) begin
      o_grant = g1; o_busy = b1; o_armed = a1; o_err = e1; o_ce = ce1; o_we = we1; o_data = d1;
    end else begin
      o_grant = g0; o_busy = b0; o_armed = a0; o_err = e0; o_ce = ce0; o_we = we0; o_data = d0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One reboot attempt on instance s, checked cycle by cycle against the reference timeline.
  task automatic run_tx(input bit s, input logic [1:0] rv, input logic [1:0] sl0, input logic [1:0] sl1,
                        input int abort_at, input int rst_at);
    int arm_len, nslots, seq_n, gi, slot, k;
    bit bad, abt, stop;
    logic [23:0] addr;
    logic [31:0] seq[$];
    logic [1:0]  eg;
    logic        eerr, earm, ebusy, ece;
    logic [31:0] edata;
    sel     = s;
    arm_len = s ? 0 : 16;
    nslots  = s ? 4 : 3;
    seq_n   = 7 + 8;
    do_reset();
    gi   = rv[0] ? 0 : 1;
    slot = gi == 0 ? int'(sl0) : int'(sl1);
    bad  = slot >= nslots;
    addr = 24'(slot * 256);
    abt  = !bad && abort_at >= 1 && abort_at <= arm_len;
    seq  = {};
    seq.push_back(32'hFFFFFFFF); seq.push_back(32'hAA995566); seq.push_back(32'h20000000);
    seq.push_back(32'h30020001); seq.push_back({8'h00, addr}); seq.push_back(32'h30008001);
    seq.push_back(32'h0000000F);
    for (int n = 0; n < 8; n++) seq.push_back(32'h20000000);
    stop = 1'b0;
    req = rv;
    req_slot = {sl1, sl0};
    for (int t = 0; t <= arm_len + seq_n + 4; t++) begin
      @(negedge clk);
      eg    = (t == 0) ? (gi == 0 ? 2'b01 : 2'b10) : 2'b00;
      eerr  = bad && t == 1;
      earm  = !bad && t >= 1 && t <= arm_len && (!abt || t <= abort_at);
      ebusy = !bad && (!abt || t <= abort_at);
      k     = t - arm_len - 2;
      if (!bad && !abt && k >= 0 && k < seq_n) begin
        ece = k != 0; edata = seq[k];
      end else begin
        ece = 1'b0; edata = 32'hFFFFFFFF;
      end
      n_vec++; if (o_grant !== eg) begin n_err++; $display("FAIL grant s=%0d t=%0d got %b exp %b", s, t, o_grant, eg); end
      n_vec++; if (o_err !== eerr) begin n_err++; $display("FAIL err_slot s=%0d t=%0d got %b exp %b", s, t, o_err, eerr); end
      n_vec++; if (o_armed !== earm) begin n_err++; $display("FAIL armed s=%0d t=%0d got %b exp %b", s, t, o_armed, earm); end
      if (t >= 1) begin
        n_vec++; if (o_busy !== ebusy) begin n_err++; $display("FAIL busy s=%0d t=%0d got %b exp %b", s, t, o_busy, ebusy); end
      end
      n_vec++; if (o_ce !== ece) begin n_err++; $display("FAIL icap_ce s=%0d t=%0d got %b exp %b", s, t, o_ce, ece); end
      n_vec++; if (o_we !== ece) begin n_err++; $display("FAIL icap_we s=%0d t=%0d got %b exp %b", s, t, o_we, ece); end
      n_vec++; if (o_data !== edata) begin n_err++; $display("FAIL icap_data s=%0d t=%0d got %h exp %h", s, t, o_data, edata); end
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({o_grant, o_busy, o_armed, o_err, o_ce, o_we} !== 7'b0 || o_data !== 32'hFFFFFFFF) begin
          n_err++;
          $display("FAIL async_rst t=%0d got g=%b b=%b a=%b e=%b ce=%b we=%b d=%h exp zeros/FFFFFFFF",
                   t, o_grant, o_busy, o_armed, o_err, o_ce, o_we, o_data);
        end
        stop = 1'b1;
      end
      if (t == 0) begin
        req      = (bad || abt) ? 2'b00 : 2'($urandom);
        req_slot = 4'($urandom);
      end
      abort = (t == abort_at);
      if (stop) break;
    end
    req = '0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_vec++;
      if ({o_grant, o_busy, o_armed, o_err, o_ce, o_we} !== 7'b0 || o_data !== 32'hFFFFFFFF) begin
        n_err++;
        $display("FAIL reset_state s=%0d got g=%b b=%b a=%b e=%b ce=%b we=%b d=%h exp zeros/FFFFFFFF",
                 s, o_grant, o_busy, o_armed, o_err, o_ce, o_we, o_data);
      end
    end
  endtask

  task automatic test_single();
    run_tx(1'b0, 2'b01, 2'd2, 2'd0, -1, -1);
  endtask

  task automatic test_both_req();
    run_tx(1'b0, 2'b11, 2'd1, 2'd3, -1, -1);
  endtask

  task automatic test_abort();
    run_tx(1'b0, 2'b01, 2'd2, 2'd1, 5, -1);
    req = 2'b01;
    req_slot = 4'b0001;
    @(negedge clk);
    req = 2'b00;
    n_vec++; if (o_grant !== 2'b01) begin n_err++; $display("FAIL regrant got %b exp 01", o_grant); end
    @(negedge clk);
    n_vec++; if (o_armed !== 1'b1) begin n_err++; $display("FAIL rearm got %b exp 1", o_armed); end
  endtask

  task automatic test_bad_slot();
    run_tx(1'b0, 2'b01, 2'd3, 2'd0, -1, -1);
    run_tx(1'b0, 2'b10, 2'd0, 2'd3, 7, -1);
  endtask

  task automatic test_arm0();
    run_tx(1'b1, 2'b10, 2'd0, 2'd3, -1, -1);
  endtask

  task automatic test_rst_mid_send();
    run_tx(1'b0, 2'b01, 2'd1, 2'd0, -1, 16 + 2 + 3);
    run_tx(1'b0, 2'b01, 2'd2, 2'd0, -1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit s;
      logic [1:0] rv;
      int ab, pick;
      s  = 1'($urandom);
      rv = 2'($urandom_range(1, 3));
      pick = $urandom_range(0, 2);
      if (pick == 0)               ab = -1;
      else if (pick == 1 && !s)    ab = $urandom_range(1, 16);
      else                         ab = (s ? 0 : 16) + 2 + $urandom_range(0, 14);
      run_tx(s, rv, 2'($urandom), 2'($urandom), ab, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_req();
    test_abort();
    test_bad_slot();
    test_arm0();
    test_rst_mid_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icap_reboot_sched.md
Name: icap_reboot_sched

Overview:
- Arbitrated warm-reboot scheduler in front of the ICAPE2 wrapper (active-high ce/we/data in; the wrapper inverts and bit-swaps).
- Several requesters (menu core, hotkey, watchdog) ask for a reboot into a numbered flash slot.
- The block picks one requester by fixed priority and looks up that slot's WBSTAR address.
- It runs an abortable arming delay, then emits the UG470 IPROG word sequence, one word per clk, and locks out until reset.

Parameters:
- NUM_REQ, 2: number of requesters. Index 0 has the highest priority.
- NUM_SLOTS, 4: number of boot slots.
- SLOT_W, 2: width of a slot index.
- SLOT_BASE, {24'h000300,24'h000200,24'h000100,24'h000000}: packed NUM_SLOTS×24 table. Entry s sits in bits [24s+23:24s] and is written to WBSTAR[23:0].
- ARM_CYCLES, 16: cycles spent in ARM before the first ICAP word. 0 skips ARM.
- TRAIL_NOPS, 8: NOP words sent after the IPROG command.

Ports:
- clk  in  1  ICAP clock, ≤20 MHz.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per requester.
- req_slot  in  NUM_REQ*SLOT_W  slot per requester. Requester i uses bits [SLOT_W*i+SLOT_W-1:SLOT_W*i].
- grant  out  NUM_REQ  one-hot, 1-cycle acceptance pulse.
- abort  in  1  cancels a pending reboot while in ARM.
- busy  out  1  high in any state other than IDLE.
- armed  out  1  high only in ARM.
- err_slot  out  1  1-cycle pulse when the granted slot is ≥ NUM_SLOTS.
- icap_ce  out  1  active-high ICAP enable.
- icap_we  out  1  active-high ICAP write.
- icap_data  out  32  ICAP word, not yet swapped.

Behaviour:
- Reset values: grant=0, busy=0, armed=0, err_slot=0, icap_ce=0, icap_we=0, icap_data=32'hFFFFFFFF. State=IDLE, all counters 0. Reset is honoured in every state, including mid-SEND and HALT.
- All outputs are registered.
- States and transitions:
  - IDLE: if any req bit is high, grant the lowest set index i (grant[i]=1 for that cycle) and latch its slot. Call this cycle T.
    - If the slot is ≥ NUM_SLOTS: pulse err_slot at T+1 and stay in IDLE. No ICAP activity.
    - Otherwise: latch addr = SLOT_BASE[slot]. Go to ARM, or to SEND if ARM_CYCLES=0.
  - ARM: occupies cycles T+1..T+ARM_CYCLES; a down-counter runs from ARM_CYCLES-1 to 0, then the block enters SEND.
    - abort=1 in any ARM cycle: return to IDLE next cycle. Nothing is written to ICAP.
    - New req while in ARM: ignored, no grant.
  - SEND: word index k runs 0..6+TRAIL_NOPS. Word k is visible on icap_* at cycle T+ARM_CYCLES+2+k. abort is ignored once SEND is entered.
    - k=0: ce=0, we=0, data=FFFFFFFF (dummy).
    - k=1: AA995566 (sync).
    - k=2: 20000000 (NOP).
    - k=3: 30020001 (write WBSTAR).
    - k=4: {8'h00, addr}.
    - k=5: 30008001 (write CMD).
    - k=6: 0000000F (IPROG).
    - k=7..6+TRAIL_NOPS: 20000000 (NOP).
    - For k=1..6+TRAIL_NOPS, ce=we=1.
  - HALT: entered after the last word. ce=we=0, data=FFFFFFFF. busy stays 1 and no grant is issued until rst. In silicon the FPGA reconfigures during this state.
- Simultaneous requests: only the lowest index is granted. Other requesters keep req high, and are never granted because the block ends in HALT.
- Slot and address are latched at grant. Later changes on req_slot have no effect.
- Sequence length is 7+TRAIL_NOPS words. The index counter is wide enough for that length and does not wrap.

Decomposition:
- Package icap_reboot_pkg holds:
  - state enum {IDLE, ARM, SEND, HALT};
  - word constants ICAP_DUMMY, ICAP_SYNC, ICAP_NOP, ICAP_WR_WBSTAR, ICAP_WR_CMD, ICAP_CMD_IPROG;
  - localparam SEQ_LEN = 7+TRAIL_NOPS, defined per instance.
- One sub-module, icap_seq_rom: combinational. Input is index k and addr. Output is {ce, we, data}. It holds the word table and the addr insertion.
- The top level holds the arbiter, the ARM counter, the state machine and the output registers.

Test Plan:
- req=2'b01, slot0=2, ARM_CYCLES=16 -> grant=01 at T; armed for 16 cycles; word 4 = 32'h00000200; word 6 = 0000000F at T+24; then HALT with busy=1.
- req=2'b11 in the same cycle, slot0=1, slot1=3 -> grant=01 only; WBSTAR word = 00000100; req1 never granted.
- abort pulsed at the 5th ARM cycle -> IDLE next cycle; icap_ce never asserted; a new req is then granted normally.
- NUM_SLOTS=3, req0 with slot=3 -> grant pulse at T, err_slot pulse at T+1, state stays IDLE, no ICAP activity.
- ARM_CYCLES=0 -> dummy word at T+2, sync AA995566 with ce=we=1 at T+3, then 7+TRAIL_NOPS words back-to-back with no gaps.
- rst asserted at SEND k=3 -> all outputs return to reset values asynchronously; after release, a new req restarts from the dummy word.
